pwm_fade_ctrl: RTL and testbench

Duty-cycle sequencer for the LED PWM path. It sits between the switch inputs and the 8-bit duty input of the PWM generator, and replaces the direct switch-to-duty connection with a controlled trajectory. It supports three modes: immediate (direct), linear ramp to a target, and continuous breathing between 0 and the target, all paced by a programmable step divider.

---
 rtl/pwm_fade_ctrl.sv | 133 +++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// pwm_fade_ctrl : duty-cycle sequencer (direct / linear ramp / breathe) for the LED PWM path
// Revision      : 1.0
// ============================================================================
module pwm_fade_ctrl #(
  parameter int HOLD_TICKS = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       target_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] step_div_i,
  output logic [7:0]       duty_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             at_target_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    DOWN    = 3'd2,
    HOLD_HI = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t           state;
  logic [7:0]       duty;
  logic             busy;
  logic [DIV_W-1:0] cnt;
  logic [7:0]       hold_cnt;
  logic [1:0]       mode_prev;

  logic             mode_chg;
  logic             tick;
  logic             is_direct;
  logic             use_ramp;
  logic             hold_done;
  logic [DIV_W-1:0] cnt_run;
  logic [7:0]       duty_inc;
  logic [7:0]       duty_dec;
  state_t           ramp_state;

  assign mode_chg   = (mode_i != mode_prev);
  // a mode switch restarts the step period, so no step is taken on that cycle
  assign tick       = (state != IDLE) && !mode_chg && (cnt >= step_div_i);
  assign is_direct  = (mode_i == 2'b00) || (mode_i == 2'b11);
  assign use_ramp   = (mode_i == 2'b01) || (target_i == 8'd0);
  assign cnt_run    = (state == IDLE || mode_chg || tick) ? '0 : cnt + DIV_W'(1);
  // the tick that enters a hold already counts as the first dwell tick
  assign hold_done  = ({1'b0, hold_cnt} + 9'd2) >= 9'(HOLD_TICKS);
  assign duty_inc   = (duty == 8'hFF) ? duty : duty + 8'd1;
  assign duty_dec   = (duty == 8'h00) ? duty : duty - 8'd1;
  assign ramp_state = (duty < target_i) ? UP : ((duty > target_i) ? DOWN : IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty      <= 8'd0;
      busy      <= 1'b0;
      cnt       <= '0;
      hold_cnt  <= 8'd0;
      mode_prev <= 2'b00;
    end else begin
      mode_prev <= mode_i;
      if (is_direct) begin
        state    <= IDLE;
        busy     <= 1'b0;
        duty     <= target_i;
        cnt      <= '0;
        hold_cnt <= 8'd0;
      end else if (use_ramp) begin
        state    <= ramp_state;
        busy     <= (ramp_state != IDLE);
        cnt      <= (ramp_state == IDLE) ? '0 : cnt_run;
        hold_cnt <= 8'd0;
        if (tick && state == UP && duty < target_i) begin
          duty <= duty_inc;
        end else if (tick && state == DOWN && duty > target_i) begin
          duty <= duty_dec;
        end
      end else if (mode_chg || state == IDLE) begin
        state    <= UP;
        busy     <= 1'b1;
        cnt      <= '0;
        hold_cnt <= 8'd0;
      end else begin
        busy <= 1'b1;
        cnt  <= cnt_run;
        if (tick) begin
          case (state)
            UP: begin
              if (duty < target_i) begin
                duty <= duty_inc;
              end else if (duty > target_i) begin
                duty <= duty_dec;
              end else begin
                state    <= HOLD_HI;
                hold_cnt <= 8'd0;
              end
            end
            HOLD_HI: begin
              if (hold_done) state <= DOWN;
              else           hold_cnt <= hold_cnt + 8'd1;
            end
            DOWN: begin
              if (duty == 8'd0) begin
                state    <= HOLD_LO;
                hold_cnt <= 8'd0;
              end else begin
                duty <= duty_dec;
              end
            end
            HOLD_LO: begin
              if (hold_done) state <= UP;
              else           hold_cnt <= hold_cnt + 8'd1;
            end
            default: state <= UP;
          endcase
        end
      end
    end
  end

  assign duty_o      = duty;
  assign state_o     = state;
  assign busy_o      = busy;
  assign at_target_o = (duty == target_i);

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pwm_fade_ctrl : vector table, directed corner sequences and randomized run vs. reference model
// Revision         : 1.0
// ============================================================================
module tb_pwm_fade_ctrl;

  localparam int HOLD   = 2;
  localparam int S_IDLE = 0;
  localparam int S_UP   = 1;
  localparam int S_DOWN = 2;
  localparam int S_HHI  = 3;
  localparam int S_HLO  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  target = 8'd0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] step_div = 16'd0;
  logic [7:0]  duty;
  logic [2:0]  state;
  logic        busy;
  logic        at_target;

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_fade_ctrl #(.HOLD_TICKS(HOLD), .DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .target_i   (target),
    .mode_i     (mode),
    .step_div_i (step_div),
    .duty_o     (duty),
    .state_o    (state),
    .busy_o     (busy),
    .at_target_o(at_target)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout, got duty %0d", name, duty);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int d, input int s, input int b);
    check({tag, ".duty"}, duty, d);
    check({tag, ".state"}, state, s);
    check({tag, ".busy"}, busy, b);
    check({tag, ".at_target"}, at_target, (d == int'(target)) ? 1 : 0);
  endtask

  // Reference model: spec rules in plain integer arithmetic.
  int md, ms, mc, mdwell, mprev;

  task automatic model_reset();
    md = 0; ms = S_IDLE; mc = 0; mdwell = 0; mprev = 0;
  endtask

  task automatic model_clock(input int mo, input int tg, input int dv);
    bit chg, tk;
    int dir, nxt, period_cnt;
    chg = (mo != mprev);
    mprev = mo;
    tk = (ms != S_IDLE) && !chg && (mc >= dv);
    period_cnt = (ms == S_IDLE || chg || tk) ? 0 : mc + 1;
    if (mo == 0 || mo == 3) begin
      md = tg; ms = S_IDLE; mc = 0;
    end else if (mo == 1 || tg == 0) begin
      nxt = (md < tg) ? S_UP : (md > tg) ? S_DOWN : S_IDLE;
      dir = (ms == S_UP) ? 1 : (ms == S_DOWN) ? -1 : 0;
      if (tk && dir * (tg - md) > 0) md = md + dir;
      ms = nxt;
      mc = (nxt == S_IDLE) ? 0 : period_cnt;
    end else if (chg || ms == S_IDLE) begin
      ms = S_UP; mc = 0;
    end else begin
      mc = period_cnt;
      if (tk) begin
        if (ms == S_UP) begin
          if (md == tg) begin ms = S_HHI; mdwell = 1; end
          else md = md + ((tg > md) ? 1 : -1);
        end else if (ms == S_HHI) begin
          mdwell++;
          if (mdwell >= HOLD) ms = S_DOWN;
        end else if (ms == S_DOWN) begin
          if (md == 0) begin ms = S_HLO; mdwell = 1; end
          else md = md - 1;
        end else if (ms == S_HLO) begin
          mdwell++;
          if (mdwell >= HOLD) ms = S_UP;
        end
      end
    end
    if (md > 255) md = 255;
    if (md < 0) md = 0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  tgt;
    logic [15:0] dv;
    int          waits;
    int          duty;
    int          st;
    int          busy;
  } vec_t;

  vec_t vt[19];
  int   bpat_d[10] = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0};
  int   bpat_s[10] = '{1, 1, 1, 3, 2, 2, 2, 2, 4, 1};

  initial begin
    vt[0]  = '{2'd0, 8'h5A, 16'd0, 1,   8'h5A, S_IDLE, 0};
    vt[1]  = '{2'd3, 8'h33, 16'd0, 1,   8'h33, S_IDLE, 0};
    vt[2]  = '{2'd0, 8'd0,  16'd0, 1,   0,     S_IDLE, 0};
    vt[3]  = '{2'd1, 8'd10, 16'd3, 4,   0,     S_UP,   1};
    vt[4]  = '{2'd1, 8'd10, 16'd3, 1,   1,     S_UP,   1};
    vt[5]  = '{2'd1, 8'd10, 16'd3, 4,   2,     S_UP,   1};
    vt[6]  = '{2'd1, 8'd10, 16'd3, 32,  10,    S_UP,   1};
    vt[7]  = '{2'd1, 8'd10, 16'd3, 1,   10,    S_IDLE, 0};
    vt[8]  = '{2'd1, 8'd4,  16'd3, 1,   10,    S_DOWN, 1};
    vt[9]  = '{2'd1, 8'd4,  16'd3, 24,  4,     S_DOWN, 1};
    vt[10] = '{2'd1, 8'd4,  16'd3, 1,   4,     S_IDLE, 0};
    vt[11] = '{2'd1, 8'd200,16'd0, 47,  50,    S_UP,   1};
    vt[12] = '{2'd1, 8'd30, 16'd0, 1,   50,    S_DOWN, 1};
    vt[13] = '{2'd1, 8'd30, 16'd0, 20,  30,    S_DOWN, 1};
    vt[14] = '{2'd1, 8'd30, 16'd0, 1,   30,    S_IDLE, 0};
    vt[15] = '{2'd1, 8'd255,16'd0, 1,   30,    S_UP,   1};
    vt[16] = '{2'd1, 8'd255,16'd0, 300, 255,   S_IDLE, 0};
    vt[17] = '{2'd2, 8'd0,  16'd0, 1,   255,   S_DOWN, 1};
    vt[18] = '{2'd2, 8'd0,  16'd0, 256, 0,     S_IDLE, 0};

    // reset state
    edges(2);
    check_out("reset", 0, S_IDLE, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      mode = vt[i].mode; target = vt[i].tgt; step_div = vt[i].dv;
      edges(vt[i].waits);
      check_out($sformatf("vec%0d", i), vt[i].duty, vt[i].st, vt[i].busy);
    end

    // breathe, target 3, divider 0
    target = 8'd3;
    edges(1);
    check_out("breathe.e1", 0, S_UP, 1);
    for (int e = 2; e <= 31; e++) begin
      edges(1);
      check($sformatf("breathe.e%0d.duty", e), duty, bpat_d[(e - 2) % 10]);
      check($sformatf("breathe.e%0d.state", e), state, bpat_s[(e - 2) % 10]);
    end

    // breathe -> ramp at duty 2 with target 2
    begin
      int k = 0;
      while (duty != 8'd2 && k < 20) begin edges(1); k++; end
      if (duty != 8'd2) timeout("breathe_to_ramp.wait");
    end
    mode = 2'd1; target = 8'd2;
    edges(1);
    check_out("breathe_to_ramp", 2, S_IDLE, 0);

    // divider drop mid-count
    target = 8'd200; step_div = 16'd100;
    edges(51);
    check_out("divdrop.before", 2, S_UP, 1);
    step_div = 16'd2;
    edges(1);
    check("divdrop.tick.duty", duty, 3);
    edges(3);
    check("divdrop.next.duty", duty, 4);

    // asynchronous reset mid-ramp at duty 100
    step_div = 16'd0;
    begin
      int k = 0;
      while (duty != 8'd100 && k < 300) begin edges(1); k++; end
      if (duty != 8'd100) timeout("async_reset.wait");
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset.duty", duty, 0);
    check("async_reset.state", state, S_IDLE);
    check("async_reset.busy", busy, 0);
    mode = 2'd1; target = 8'd0;
    edges(1);
    rst_n = 1'b1;
    edges(5);
    check_out("post_reset_ramp0", 0, S_IDLE, 0);

    // randomized run against the reference model
    rst_n = 1'b0;
    mode = 2'd0; target = 8'd0; step_div = 16'd0;
    edges(2);
    model_reset();
    rst_n = 1'b1;
    begin
      int left = 0;
      for (int i = 0; i < 4000; i++) begin
        if (left == 0) begin
          case ($urandom_range(0, 5))
            0:       mode = 2'd0;
            1:       mode = 2'd3;
            2, 3:    mode = 2'd1;
            default: mode = 2'd2;
          endcase
          target   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
          step_div = 16'($urandom_range(0, 3));
          left     = $urandom_range(1, 60);
        end
        left--;
        model_clock(int'(mode), int'(target), int'(step_div));
        edges(1);
        check("rand.duty", duty, md);
        check("rand.state", state, ms);
        check("rand.busy", busy, (ms != S_IDLE) ? 1 : 0);
        check("rand.at_target", at_target, (md == int'(target)) ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
